// File: rtl/updi_txn_pkg.sv
// updi_txn shared types.
// Engine state encoding for the UPDI byte transaction FSM.
package updi_txn_pkg;

  typedef enum logic [3:0] {
    IDLE,
    SEND,
    ECHO_WAIT,
    ECHO_REQ,
    ECHO_CAP,
    RESP_WAIT,
    RESP_REQ,
    RESP_CAP,
    RESP_OUT,
    DONE
  } updi_txn_state;

endpackage

// File: rtl/updi_txn_if.sv
// updi_txn bundle: command, byte streams, status and uart_fifo side.
// slave is the engine view, master the caller/FIFO view.
interface updi_txn_if #(
  parameter int DATA_BITS    = 8,
  parameter int MAX_TX_BYTES = 16,
  parameter int MAX_RX_BYTES = 16
) ();

  localparam int TXW = $clog2(MAX_TX_BYTES + 1);
  localparam int RXW = $clog2(MAX_RX_BYTES + 1);

  logic                 cmd_start;
  logic [TXW-1:0]       cmd_tx_len;
  logic [RXW-1:0]       cmd_rx_len;
  logic                 cmd_ready;
  logic [DATA_BITS-1:0] in_data;
  logic                 in_valid;
  logic                 in_ready;
  logic [DATA_BITS-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic                 done;
  logic                 err_echo;
  logic                 err_timeout;
  logic                 err_rx;
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_fifo_wr_en;
  logic                 tx_fifo_full;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_fifo_rd_en;
  logic                 rx_fifo_empty;
  logic                 rx_error;

  modport slave (
    input  cmd_start, cmd_tx_len, cmd_rx_len,
    input  in_data, in_valid, out_ready,
    input  tx_fifo_full, rx_data,
    input  rx_fifo_empty, rx_error,
    output cmd_ready, in_ready,
    output out_data, out_valid, done,
    output err_echo, err_timeout, err_rx,
    output tx_data, tx_fifo_wr_en,
    output rx_fifo_rd_en
  );

  modport master (
    output cmd_start, cmd_tx_len, cmd_rx_len,
    output in_data, in_valid, out_ready,
    output tx_fifo_full, rx_data,
    output rx_fifo_empty, rx_error,
    input  cmd_ready, in_ready,
    input  out_data, out_valid, done,
    input  err_echo, err_timeout, err_rx,
    input  tx_data, tx_fifo_wr_en,
    input  rx_fifo_rd_en
  );

endinterface

// File: rtl/fifo.sv
// Generic synchronous FIFO with show-ahead read data.
// i_clr empties it in one cycle without touching storage.
module fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] P_LAST = AW'(DEPTH - 1);
  localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wp;
  logic [AW-1:0]    r_rp;
  logic [CW-1:0]    r_cnt;
  logic             w_wr;
  logic             w_rd;

  assign o_full    = (r_cnt == C_FULL);
  assign o_empty   = (r_cnt == '0);
  assign w_wr      = i_wr_en && !o_full;
  assign w_rd      = i_rd_en && !o_empty;
  assign o_rd_data = r_mem[r_rp];

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wp] <= i_wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_wr) r_wp <= (r_wp == P_LAST) ? '0 : r_wp + 1'b1;
      if (w_rd) r_rp <= (r_rp == P_LAST) ? '0 : r_rp + 1'b1;
      unique case ({w_wr, w_rd})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/updi_txn.sv
// UPDI byte transaction engine: send N bytes, drain N echoes,
// return M response bytes, with echo/timeout/line-error flags.
module updi_txn
  import updi_txn_pkg::*;
#(
  parameter int DATA_BITS      = 8,
  parameter int MAX_TX_BYTES   = 16,
  parameter int MAX_RX_BYTES   = 16,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  updi_txn_if.slave  bus
);

  localparam int TXW = $clog2(MAX_TX_BYTES + 1);
  localparam int RXW = $clog2(MAX_RX_BYTES + 1);
  localparam int TMW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TXW-1:0] TX_MAX  = TXW'(MAX_TX_BYTES);
  localparam logic [RXW-1:0] RX_MAX  = RXW'(MAX_RX_BYTES);
  localparam logic [TMW-1:0] TM_LAST = TMW'(TIMEOUT_CYCLES - 1);

  updi_txn_state r_state;
  updi_txn_state w_next;

  logic [TXW-1:0]       r_tx_len;
  logic [TXW-1:0]       r_sent;
  logic [TXW-1:0]       r_echo_cnt;
  logic [RXW-1:0]       r_rx_len;
  logic [RXW-1:0]       r_rx_cnt;
  logic [TMW-1:0]       r_tmo;
  logic [DATA_BITS-1:0] r_out_data;
  logic                 r_err_echo;
  logic                 r_err_tmo;
  logic                 r_err_rx;

  logic [TXW-1:0]       w_tx_sat;
  logic [RXW-1:0]       w_rx_sat;
  logic                 w_start;
  logic                 w_in_ready;
  logic                 w_fire;
  logic                 w_wait;
  logic                 w_tmo_evt;
  logic                 w_rd_en;
  logic                 w_out_valid;
  logic                 w_done;
  logic                 w_tx_last;
  logic                 w_echo_last;
  logic                 w_rx_last;
  logic                 w_echo_pop;
  logic                 w_echo_clr;
  logic                 w_echo_full;
  logic                 w_echo_empty;
  logic                 w_echo_bad;
  logic [DATA_BITS-1:0] w_echo_head;

  assign w_tx_sat = (bus.cmd_tx_len > TX_MAX) ? TX_MAX : bus.cmd_tx_len;
  assign w_rx_sat = (bus.cmd_rx_len > RX_MAX) ? RX_MAX : bus.cmd_rx_len;

  assign w_start     = (r_state == IDLE) && bus.cmd_start;
  assign w_fire      = bus.in_valid && w_in_ready;
  assign w_wait      = (r_state == ECHO_WAIT) || (r_state == RESP_WAIT);
  assign w_tmo_evt   = w_wait && bus.rx_fifo_empty && (r_tmo == TM_LAST);
  assign w_tx_last   = (r_sent == r_tx_len - 1'b1);
  assign w_echo_last = (r_echo_cnt == r_tx_len - 1'b1);
  assign w_rx_last   = (r_rx_cnt == r_rx_len - 1'b1);

  // An echo with nothing left to match against is also a mismatch
  assign w_echo_bad = w_echo_empty || (bus.rx_data != w_echo_head);

  fifo #(
    .DEPTH (MAX_TX_BYTES),
    .WIDTH (DATA_BITS)
  ) u_echo (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (w_echo_clr),
    .i_wr_en   (w_fire),
    .i_wr_data (bus.in_data),
    .i_rd_en   (w_echo_pop),
    .o_rd_data (w_echo_head),
    .o_full    (w_echo_full),
    .o_empty   (w_echo_empty)
  );

  always_comb begin
    w_next      = r_state;
    w_in_ready  = 1'b0;
    w_rd_en     = 1'b0;
    w_out_valid = 1'b0;
    w_done      = 1'b0;
    w_echo_pop  = 1'b0;
    w_echo_clr  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.cmd_start) begin
          if (w_tx_sat != '0)      w_next = SEND;
          else if (w_rx_sat != '0) w_next = RESP_WAIT;
          else                     w_next = DONE;
        end
      end
      SEND: begin
        w_in_ready = !bus.tx_fifo_full && !w_echo_full
                     && (r_sent < r_tx_len);
        if (bus.in_valid && w_in_ready && w_tx_last)
          w_next = ECHO_WAIT;
      end
      ECHO_WAIT: begin
        if (!bus.rx_fifo_empty) begin
          w_next = ECHO_REQ;
        end else if (w_tmo_evt) begin
          w_next     = DONE;
          w_echo_clr = 1'b1;
        end
      end
      ECHO_REQ: begin
        w_rd_en = 1'b1;
        w_next  = ECHO_CAP;
      end
      ECHO_CAP: begin
        w_echo_pop = 1'b1;
        if (!w_echo_last)        w_next = ECHO_WAIT;
        else if (r_rx_len != '0) w_next = RESP_WAIT;
        else                     w_next = DONE;
      end
      RESP_WAIT: begin
        if (!bus.rx_fifo_empty) begin
          w_next = RESP_REQ;
        end else if (w_tmo_evt) begin
          w_next     = DONE;
          w_echo_clr = 1'b1;
        end
      end
      RESP_REQ: begin
        w_rd_en = 1'b1;
        w_next  = RESP_CAP;
      end
      RESP_CAP: w_next = RESP_OUT;
      RESP_OUT: begin
        w_out_valid = 1'b1;
        if (bus.out_ready)
          w_next = w_rx_last ? DONE : RESP_WAIT;
      end
      DONE: begin
        w_done = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_tx_len   <= '0;
      r_rx_len   <= '0;
      r_sent     <= '0;
      r_echo_cnt <= '0;
      r_rx_cnt   <= '0;
      r_tmo      <= '0;
      r_out_data <= '0;
      r_err_echo <= 1'b0;
      r_err_tmo  <= 1'b0;
      r_err_rx   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_start) begin
        r_tx_len   <= w_tx_sat;
        r_rx_len   <= w_rx_sat;
        r_sent     <= '0;
        r_echo_cnt <= '0;
        r_rx_cnt   <= '0;
        r_err_echo <= 1'b0;
        r_err_tmo  <= 1'b0;
        r_err_rx   <= 1'b0;
      end
      if (w_fire) r_sent <= r_sent + 1'b1;
      if (r_state == ECHO_CAP) begin
        r_echo_cnt <= r_echo_cnt + 1'b1;
        if (w_echo_bad) r_err_echo <= 1'b1;
      end
      if (r_state == RESP_CAP) r_out_data <= bus.rx_data;
      if (w_out_valid && bus.out_ready) r_rx_cnt <= r_rx_cnt + 1'b1;
      if (w_tmo_evt) r_err_tmo <= 1'b1;
      if (bus.rx_error && (r_state != IDLE)) r_err_rx <= 1'b1;
      // Idle-wait counter: restarts whenever a wait state is left
      r_tmo <= (w_wait && (w_next == r_state)) ? r_tmo + 1'b1 : '0;
    end
  end

  assign bus.cmd_ready     = (r_state == IDLE);
  assign bus.in_ready      = w_in_ready;
  assign bus.tx_fifo_wr_en = w_fire;
  assign bus.tx_data       = (r_state == SEND) ? bus.in_data : '0;
  assign bus.rx_fifo_rd_en = w_rd_en;
  assign bus.out_data      = r_out_data;
  assign bus.out_valid     = w_out_valid;
  assign bus.done          = w_done;
  assign bus.err_echo      = r_err_echo;
  assign bus.err_timeout   = r_err_tmo;
  assign bus.err_rx        = r_err_rx;

endmodule

// File: tb/tb_updi_txn.sv
// Bench for updi_txn: behavioural uart_fifo with tx->rx loopback,
// vector table plus hand sequences, response scoreboard.
module tb_updi_txn;

  localparam int DB     = 8;
  localparam int MTX    = 16;
  localparam int MRX    = 16;
  localparam int TMO    = 300;
  localparam int TXD    = 4;
  localparam int BYTE_T = 12;
  localparam int BUDGET = 3000;
  localparam int NV     = 7;

  typedef struct {
    int         tx_len;
    int         rx_len;
    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] b2;
    int         corrupt_at;
    int         n_resp;
    logic [7:0] r0;
    bit         tog;
    bit         rxerr;
    int         exp_sent;
    bit         exp_echo;
    bit         exp_tmo;
    bit         exp_rx;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  updi_txn_if #(.DATA_BITS(DB), .MAX_TX_BYTES(MTX),
                .MAX_RX_BYTES(MRX)) bus ();

  updi_txn #(
    .DATA_BITS      (DB),
    .MAX_TX_BYTES   (MTX),
    .MAX_RX_BYTES   (MRX),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] q_tx[$];
  logic [7:0] q_rx[$];
  logic [7:0] q_inj[$];
  logic [7:0] q_exp[$];
  logic [7:0] m_b;
  logic [7:0] m_e;
  int   wire_cnt = 0;
  int   echo_idx = 0;
  int   corrupt_at = -1;
  int   n_wr = 0;
  int   n_viol = 0;
  int   n_fire = 0;
  int   done_cnt = 0;
  bit   done_seen = 0;
  bit   prev_rd = 0;
  vec_t cv;
  vec_t tv[NV];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] data_at(input int i);
    if (i == 0) return cv.b0;
    if (i == 1) return cv.b1;
    if (i == 2) return cv.b2;
    return 8'(i);
  endfunction

  function automatic logic [7:0] resp_at(input vec_t v, input int j);
    return v.r0 + 8'(j * 17);
  endfunction

  // uart_fifo model: TX FIFO drained onto the wire one byte per
  // BYTE_T cycles, looped back into RX; responses follow echoes.
  always @(posedge clk) begin
    if (rst) begin
      q_tx.delete();
      q_rx.delete();
      prev_rd = 0;
      bus.rx_data       <= '0;
      bus.tx_fifo_full  <= 1'b0;
      bus.rx_fifo_empty <= 1'b1;
    end else begin
      if (bus.tx_fifo_wr_en) begin
        n_wr++;
        if (bus.tx_fifo_full) n_viol++;
        else q_tx.push_back(bus.tx_data);
      end
      if (bus.rx_fifo_rd_en) begin
        if (prev_rd || q_rx.size() == 0) n_viol++;
        if (q_rx.size() > 0) bus.rx_data <= q_rx.pop_front();
      end
      prev_rd = bus.rx_fifo_rd_en;
      wire_cnt++;
      if (wire_cnt >= BYTE_T) begin
        wire_cnt = 0;
        if (q_tx.size() > 0) begin
          m_b = q_tx.pop_front();
          if (echo_idx == corrupt_at) m_b = 8'h00;
          echo_idx++;
          q_rx.push_back(m_b);
        end else if (q_inj.size() > 0) begin
          q_rx.push_back(q_inj.pop_front());
        end
      end
      bus.tx_fifo_full  <= (q_tx.size() >= TXD);
      bus.rx_fifo_empty <= (q_rx.size() == 0);
    end
  end

  // Monitor: TX byte stream, response scoreboard, done pulses
  always @(posedge clk) begin
    if (!rst) begin
      if (bus.in_valid && bus.in_ready) begin
        chk("tx_wr_en", {31'b0, bus.tx_fifo_wr_en}, 1);
        chk("tx_data", bus.tx_data, data_at(n_fire));
        n_fire++;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (q_exp.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL resp_extra: got %0h expected none",
                   bus.out_data);
        end else begin
          m_e = q_exp.pop_front();
          chk("out_data", bus.out_data, m_e);
        end
      end
      if (bus.done) begin
        done_cnt++;
        done_seen = 1;
      end
    end
  end

  task automatic chk_reset(input string tag);
    chk({tag, "_cmd_ready"}, bus.cmd_ready, 1);
    chk({tag, "_in_ready"}, bus.in_ready, 0);
    chk({tag, "_out_valid"}, bus.out_valid, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_err_echo"}, bus.err_echo, 0);
    chk({tag, "_err_timeout"}, bus.err_timeout, 0);
    chk({tag, "_err_rx"}, bus.err_rx, 0);
    chk({tag, "_tx_wr_en"}, bus.tx_fifo_wr_en, 0);
    chk({tag, "_rx_rd_en"}, bus.rx_fifo_rd_en, 0);
    chk({tag, "_out_data"}, bus.out_data, 0);
    chk({tag, "_tx_data"}, bus.tx_data, 0);
  endtask

  task automatic start_txn(input vec_t v);
    cv = v;
    n_fire = 0;
    n_wr = 0;
    n_viol = 0;
    echo_idx = 0;
    corrupt_at = v.corrupt_at;
    done_seen = 0;
    done_cnt = 0;
    bus.in_valid = 1'b1;
    bus.in_data = data_at(0);
    bus.cmd_tx_len = 5'(v.tx_len);
    bus.cmd_rx_len = 5'(v.rx_len);
    bus.cmd_start = 1'b1;
    @(negedge clk);
    bus.cmd_start = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int eff_rx;
    int nd;
    int k;
    eff_rx = (v.rx_len > MRX) ? MRX : v.rx_len;
    nd = (v.n_resp < eff_rx) ? v.n_resp : eff_rx;
    for (int j = 0; j < v.n_resp; j++) q_inj.push_back(resp_at(v, j));
    for (int j = 0; j < nd; j++) q_exp.push_back(resp_at(v, j));
    start_txn(v);
    k = 0;
    while (!done_seen && k < BUDGET) begin
      bus.in_data = data_at(n_fire);
      bus.out_ready = v.tog ? ~bus.out_ready : 1'b1;
      bus.rx_error = v.rxerr && (k == 3);
      @(negedge clk);
      k++;
    end
    bus.in_valid = 1'b0;
    bus.rx_error = 1'b0;
    chk({tag, "_done_seen"}, {31'b0, done_seen}, 1);
    @(negedge clk);
    chk({tag, "_done_width"}, done_cnt, 1);
    chk({tag, "_cmd_ready"}, bus.cmd_ready, 1);
    chk({tag, "_err_echo"}, bus.err_echo, v.exp_echo);
    chk({tag, "_err_timeout"}, bus.err_timeout, v.exp_tmo);
    chk({tag, "_err_rx"}, bus.err_rx, v.exp_rx);
    chk({tag, "_sent"}, n_fire, v.exp_sent);
    chk({tag, "_fifo_wr"}, n_wr, v.exp_sent);
    chk({tag, "_fifo_viol"}, n_viol, 0);
    chk({tag, "_rx_left"}, q_rx.size(), 0);
    chk({tag, "_resp_left"}, q_exp.size(), 0);
    q_inj.delete();
    q_exp.delete();
  endtask

  initial begin
    int lat;
    vec_t rv;
    tv[0] = '{2, 1, 8'h55, 8'hC4, 8'h00, -1, 1, 8'hA5,
              1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b0};
    tv[1] = '{3, 0, 8'h11, 8'h80, 8'h22, 1, 0, 8'h00,
              1'b0, 1'b0, 3, 1'b1, 1'b0, 1'b0};
    tv[2] = '{1, 2, 8'h3C, 8'h00, 8'h00, -1, 1, 8'h5A,
              1'b0, 1'b0, 1, 1'b0, 1'b1, 1'b0};
    tv[3] = '{16, 2, 8'h00, 8'h01, 8'h02, -1, 2, 8'hC3,
              1'b1, 1'b0, 16, 1'b0, 1'b0, 1'b0};
    tv[4] = '{20, 0, 8'h00, 8'h01, 8'h02, -1, 0, 8'h00,
              1'b0, 1'b0, 16, 1'b0, 1'b0, 1'b0};
    tv[5] = '{0, 3, 8'h00, 8'h00, 8'h00, -1, 3, 8'h12,
              1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0};
    tv[6] = '{1, 1, 8'h69, 8'h00, 8'h00, -1, 1, 8'h7E,
              1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b1};

    bus.cmd_start = 1'b0;
    bus.cmd_tx_len = '0;
    bus.cmd_rx_len = '0;
    bus.in_data = '0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.rx_error = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset("rst0");
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < NV; i++) run_vec(tv[i], $sformatf("v%0d", i));

    // Zero-length command: straight to DONE, flags cleared
    rv = '{0, 0, 8'h00, 8'h00, 8'h00, -1, 0, 8'h00,
           1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0};
    start_txn(rv);
    lat = 1;
    while (!done_seen && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    bus.in_valid = 1'b0;
    chk("zero_len_latency", lat, 2);
    @(negedge clk);
    chk("zero_len_done_width", done_cnt, 1);
    chk("zero_len_err_rx", bus.err_rx, 0);
    chk("zero_len_cmd_ready", bus.cmd_ready, 1);

    // Reset while waiting for echoes; stale echo buffer must go
    rv = '{2, 0, 8'hAA, 8'hBB, 8'h00, -1, 0, 8'h00,
           1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b0};
    start_txn(rv);
    lat = 0;
    while (n_fire < 2 && lat < 50) begin
      bus.in_data = data_at(n_fire);
      @(negedge clk);
      lat++;
    end
    bus.in_valid = 1'b0;
    chk("rst_mid_sent", n_fire, 2);
    bus.rx_error = 1'b1;
    @(negedge clk);
    bus.rx_error = 1'b0;
    @(negedge clk);
    chk("rst_mid_busy", bus.cmd_ready, 0);
    chk("rst_mid_err_rx", bus.err_rx, 1);
    rst = 1'b1;
    @(negedge clk);
    chk_reset("rst_mid");
    rst = 1'b0;
    @(negedge clk);
    run_vec(tv[0], "post_rst");

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
